// File: rtl/ysyx_23060201_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060201_mem_arbiter
// Purpose  : Shares the single data-memory port between the IFU (fetch,
//            read-only) and the LSU (load/store). Round-robin arbitration,
//            one outstanding transaction, programmable access latency.
// Ports    : clk, rst_n              - clock, synchronous active-low reset
//            ifu_req_*/ifu_addr      - IFU request channel
//            ifu_resp_*/ifu_rdata    - IFU response channel
//            lsu_req_*/lsu_wen/addr/wdata/wmask - LSU request channel
//            lsu_resp_*/lsu_rdata    - LSU response channel
//            mem_ren/raddr/rdata     - memory read port (rdata combinational)
//            mem_wen/waddr/wdata/wmask - memory write port
// Params   : LATENCY - wait cycles between accept and memory access (0..15)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060201_mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic G_IFU = 1'b0;
  localparam logic G_LSU = 1'b1;

  // Terminal wait count; unused when LATENCY is 0 (IDLE jumps straight to ACCESS).
  localparam int         LAST_CNT   = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] LAST_CNT_W = LAST_CNT[3:0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;

  logic        sel_grant;
  logic        accept;
  logic        resp_fire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= G_LSU;   // so the IFU wins the first tie
      grant_q      <= G_IFU;
      wen_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      ifu_rdata_q  <= 32'd0;
      lsu_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    // On a tie the requester that did not win last time is served.
    if (ifu_req_valid && lsu_req_valid) begin
      sel_grant = (last_grant_q == G_LSU) ? G_IFU : G_LSU;
    end else if (lsu_req_valid) begin
      sel_grant = G_LSU;
    end else begin
      sel_grant = G_IFU;
    end

    accept    = rst_n && (state_q == S_IDLE) && (ifu_req_valid || lsu_req_valid);
    resp_fire = (state_q == S_RESP) &&
                ((grant_q == G_IFU) ? ifu_resp_ready : lsu_resp_ready);

    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          grant_d      = sel_grant;
          last_grant_d = sel_grant;
          cnt_d        = 4'd0;
          if (sel_grant == G_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            // Fetches never write; write data/mask keep their previous values.
            addr_d = ifu_addr;
            wen_d  = 1'b0;
          end
          state_d = (LATENCY > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT_W) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Only the granted port's response register changes.
        if (grant_q == G_IFU) begin
          ifu_rdata_d = mem_rdata;
        end else begin
          lsu_rdata_d = wen_q ? 32'd0 : mem_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ifu_req_ready  = accept && (sel_grant == G_IFU);
    lsu_req_ready  = accept && (sel_grant == G_LSU);

    mem_wen        = (state_q == S_ACCESS) && (grant_q == G_LSU) && wen_q;
    mem_ren        = (state_q == S_ACCESS) && !((grant_q == G_LSU) && wen_q);
    mem_raddr      = addr_q;
    mem_waddr      = addr_q;
    mem_wdata      = wdata_q;
    mem_wmask      = mem_wen ? wmask_q : 4'd0;

    ifu_resp_valid = (state_q == S_RESP) && (grant_q == G_IFU);
    lsu_resp_valid = (state_q == S_RESP) && (grant_q == G_LSU);
    ifu_rdata      = ifu_rdata_q;
    lsu_rdata      = lsu_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060201_mem_arbiter
// Purpose  : Self-checking bench for ysyx_23060201_mem_arbiter. Three
//            instances (LATENCY 0, 1, 15) share a clock and a word memory;
//            instance 1 receives randomized IFU/LSU traffic checked against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060201_mem_arbiter;

  localparam int N    = 3;
  localparam int MLAT = 1;   // latency of the randomly driven instance 1

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h0000_0413;
    return 32'hA500_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_load = 1'b1;

  logic        ifu_req_valid  [N];
  logic        ifu_req_ready  [N];
  logic [31:0] ifu_addr       [N];
  logic        ifu_resp_valid [N];
  logic        ifu_resp_ready [N];
  logic [31:0] ifu_rdata      [N];
  logic        lsu_req_valid  [N];
  logic        lsu_req_ready  [N];
  logic        lsu_wen        [N];
  logic [31:0] lsu_addr       [N];
  logic [31:0] lsu_wdata      [N];
  logic [3:0]  lsu_wmask      [N];
  logic        lsu_resp_valid [N];
  logic        lsu_resp_ready [N];
  logic [31:0] lsu_rdata      [N];
  logic        mem_ren        [N];
  logic [31:0] mem_raddr      [N];
  logic        mem_wen        [N];
  logic [31:0] mem_waddr      [N];
  logic [31:0] mem_wdata      [N];
  logic [3:0]  mem_wmask      [N];
  logic [31:0] mem_rdata      [N];

  logic [31:0] mem_arr [4096];   // environment memory, word index = addr[13:2]
  logic [31:0] ref_mem [4096];   // reference model's view of memory

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    ysyx_23060201_mem_arbiter #(.LATENCY(lat_of(i))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid[i]), .ifu_req_ready(ifu_req_ready[i]),
      .ifu_addr(ifu_addr[i]), .ifu_resp_valid(ifu_resp_valid[i]),
      .ifu_resp_ready(ifu_resp_ready[i]), .ifu_rdata(ifu_rdata[i]),
      .lsu_req_valid(lsu_req_valid[i]), .lsu_req_ready(lsu_req_ready[i]),
      .lsu_wen(lsu_wen[i]), .lsu_addr(lsu_addr[i]), .lsu_wdata(lsu_wdata[i]),
      .lsu_wmask(lsu_wmask[i]), .lsu_resp_valid(lsu_resp_valid[i]),
      .lsu_resp_ready(lsu_resp_ready[i]), .lsu_rdata(lsu_rdata[i]),
      .mem_ren(mem_ren[i]), .mem_raddr(mem_raddr[i]),
      .mem_wen(mem_wen[i]), .mem_waddr(mem_waddr[i]),
      .mem_wdata(mem_wdata[i]), .mem_wmask(mem_wmask[i]),
      .mem_rdata(mem_rdata[i])
    );
    assign mem_rdata[i] = mem_arr[mem_raddr[i][13:2]];
  end

  // Byte-masked memory; only instance 1 ever issues stores.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= init_word(i);
    end else if (mem_wen[1]) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[1][b]) mem_arr[mem_waddr[1][13:2]][8*b +: 8] <= mem_wdata[1][8*b +: 8];
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model --
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } lsu_req_t;

  lsu_req_t    lsu_dir[$];
  logic [31:0] ifu_dir[$];
  bit          ifu_pend, lsu_pend;

  bit          m_busy, m_owner, m_last, m_store;
  int          m_acc_cyc, m_resp_cyc;
  logic [31:0] m_addr, m_wdata, m_data, exp_ifu_rd, exp_lsu_rd;
  logic [3:0]  m_wmask;

  task automatic model_reset();
    m_busy = 0; m_last = 1'b1; exp_ifu_rd = '0; exp_lsu_rd = '0;
    ifu_pend = 0; lsu_pend = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = $urandom_range(1) ? 32'h8000_1000 : 32'h8000_0000;
    return base + 32'(4 * $urandom_range(7));
  endfunction

  task automatic run(input int ncyc, input bit tie, input int rr_pct, input bit quiet);
    for (int n = 0; n < ncyc; n++) begin
      bit ivld, lvld, any, g, respv, acc, exp_ren, exp_wen, rdy;
      lsu_req_t r;
      @(posedge clk); #1;
      cyc++;
      if (!quiet && !ifu_pend && (tie || $urandom_range(99) < 35)) begin
        ifu_pend = 1;
        ifu_addr[1] = (ifu_dir.size() > 0) ? ifu_dir.pop_front() : rand_addr();
      end else if (!ifu_pend) begin
        ifu_addr[1] = $urandom();
      end
      if (!quiet && !lsu_pend && (tie || $urandom_range(99) < 35)) begin
        lsu_pend = 1;
        if (lsu_dir.size() > 0) r = lsu_dir.pop_front();
        else begin
          r.wen = 1'($urandom_range(1)); r.addr = rand_addr();
          r.wdata = $urandom(); r.mask = 4'($urandom_range(15));
        end
        lsu_wen[1] = r.wen; lsu_addr[1] = r.addr; lsu_wdata[1] = r.wdata; lsu_wmask[1] = r.mask;
      end else if (!lsu_pend) begin
        lsu_wen[1] = 1'($urandom_range(1)); lsu_addr[1] = $urandom();
        lsu_wdata[1] = $urandom(); lsu_wmask[1] = 4'($urandom_range(15));
      end
      ifu_req_valid[1]  = ifu_pend;
      lsu_req_valid[1]  = lsu_pend;
      ifu_resp_ready[1] = ($urandom_range(99) < rr_pct);
      lsu_resp_ready[1] = ($urandom_range(99) < rr_pct);

      @(negedge clk);
      ivld = ifu_pend; lvld = lsu_pend; any = ivld || lvld;
      g = (ivld && lvld) ? !m_last : lvld;
      check("ifu_req_ready", 32'(ifu_req_ready[1]), 32'(!m_busy && any && !g));
      check("lsu_req_ready", 32'(lsu_req_ready[1]), 32'(!m_busy && any && g));

      acc     = m_busy && (cyc == m_acc_cyc);
      exp_ren = acc && !m_store;
      exp_wen = acc && m_store;
      check("mem_ren", 32'(mem_ren[1]), 32'(exp_ren));
      check("mem_wen", 32'(mem_wen[1]), 32'(exp_wen));
      check("mem_wmask", 32'(mem_wmask[1]), exp_wen ? 32'(m_wmask) : 32'd0);
      if (exp_ren) check("mem_raddr", mem_raddr[1], m_addr);
      if (exp_wen) begin
        check("mem_waddr", mem_waddr[1], m_addr);
        check("mem_wdata", mem_wdata[1], m_wdata);
      end

      if (m_busy && cyc == m_resp_cyc) begin
        if (m_owner) exp_lsu_rd = m_data; else exp_ifu_rd = m_data;
      end
      respv = m_busy && (cyc >= m_resp_cyc);
      check("ifu_resp_valid", 32'(ifu_resp_valid[1]), 32'(respv && !m_owner));
      check("lsu_resp_valid", 32'(lsu_resp_valid[1]), 32'(respv && m_owner));
      check("ifu_rdata", ifu_rdata[1], exp_ifu_rd);
      check("lsu_rdata", lsu_rdata[1], exp_lsu_rd);

      rdy = m_owner ? lsu_resp_ready[1] : ifu_resp_ready[1];
      if (respv && rdy) begin
        m_busy = 0;
      end else if (!m_busy && any) begin
        m_busy = 1; m_owner = g; m_last = g;
        m_acc_cyc = cyc + 1 + MLAT; m_resp_cyc = cyc + 2 + MLAT;
        m_addr  = g ? lsu_addr[1] : ifu_addr[1];
        m_store = g && lsu_wen[1];
        m_wdata = lsu_wdata[1]; m_wmask = lsu_wmask[1];
        if (m_store) begin
          for (int b = 0; b < 4; b++)
            if (m_wmask[b]) ref_mem[m_addr[13:2]][8*b +: 8] = m_wdata[8*b +: 8];
          m_data = 32'd0;
        end else begin
          m_data = ref_mem[m_addr[13:2]];
        end
        if (g) lsu_pend = 0; else ifu_pend = 0;
      end
    end
  endtask

  // Single IFU fetch on instance k with exact cycle-by-cycle timing checks.
  task automatic probe(input int k, input logic [31:0] a);
    int lat;
    lat = lat_of(k);
    @(posedge clk); #1;
    ifu_req_valid[k] = 1'b1; ifu_addr[k] = a; ifu_resp_ready[k] = 1'b1;
    @(negedge clk);
    check($sformatf("probe%0d_req_ready", k), 32'(ifu_req_ready[k]), 32'd1);
    @(posedge clk); #1;
    ifu_req_valid[k] = 1'b0; ifu_addr[k] = 32'hFFFF_FFFC;
    for (int c = 1; c <= lat + 2; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      check($sformatf("probe%0d_mem_ren_c%0d", k, c), 32'(mem_ren[k]), 32'(c == lat + 1));
      check($sformatf("probe%0d_resp_valid_c%0d", k, c), 32'(ifu_resp_valid[k]), 32'(c == lat + 2));
    end
    check($sformatf("probe%0d_rdata", k), ifu_rdata[k], ref_mem[a[13:2]]);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ifu_req_valid[k] = 0; ifu_addr[k] = '0; ifu_resp_ready[k] = 0;
      lsu_req_valid[k] = 0; lsu_wen[k] = 0; lsu_addr[k] = '0;
      lsu_wdata[k] = '0; lsu_wmask[k] = '0; lsu_resp_ready[k] = 0;
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst%0d_ifu_req_ready", k), 32'(ifu_req_ready[k]), 32'd0);
      check($sformatf("rst%0d_resp_valid", k), {31'd0, ifu_resp_valid[k] | lsu_resp_valid[k]}, 32'd0);
      check($sformatf("rst%0d_mem_strobe", k), {31'd0, mem_ren[k] | mem_wen[k]}, 32'd0);
      check($sformatf("rst%0d_ifu_rdata", k), ifu_rdata[k], 32'd0);
      check($sformatf("rst%0d_mem_raddr", k), mem_raddr[k], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_load = 1'b0;

    // Single fetches: LATENCY 1, 0 and 15.
    probe(1, 32'h8000_0000);
    probe(0, 32'h8000_0000);
    probe(2, 32'h8000_0004);

    // Fresh reset so the round-robin pointer starts from its reset value.
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();

    // Back-to-back ties with a directed store then load of 0x80001000.
    ifu_dir.push_back(32'h8000_0000);
    ifu_dir.push_back(32'h8000_0004);
    ifu_dir.push_back(32'h8000_0008);
    lsu_dir.push_back('{wen: 1'b1, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF, mask: 4'b0011});
    lsu_dir.push_back('{wen: 1'b0, addr: 32'h8000_1000, wdata: 32'h0, mask: 4'b0000});
    run(60, 1'b1, 100, 1'b0);
    run(1500, 1'b0, 50, 1'b0);
    run(400, 1'b0, 12, 1'b0);   // slow consumers: long response holds
    run(40, 1'b0, 100, 1'b1);   // drain
    check("drained", 32'(m_busy), 32'd0);

    // Reset while the transaction sits in WAIT.
    @(posedge clk); #1;
    lsu_req_valid[1] = 0; ifu_req_valid[1] = 1; ifu_addr[1] = 32'h8000_0010; ifu_resp_ready[1] = 1;
    @(negedge clk);
    check("rstw_accept", 32'(ifu_req_ready[1]), 32'd1);
    @(posedge clk); #1;
    ifu_req_valid[1] = 0; rst_n = 1'b0;
    @(negedge clk);
    check("rstw_wait_ren", 32'(mem_ren[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_mem_ren", 32'(mem_ren[1]), 32'd0);
    check("rstw_mem_wen", 32'(mem_wen[1]), 32'd0);
    check("rstw_mem_raddr", mem_raddr[1], 32'd0);
    check("rstw_mem_wdata", mem_wdata[1], 32'd0);
    check("rstw_mem_wmask", 32'(mem_wmask[1]), 32'd0);
    check("rstw_ifu_rdata", ifu_rdata[1], 32'd0);
    check("rstw_lsu_rdata", lsu_rdata[1], 32'd0);
    for (int c = 0; c < MLAT + 3; c++) begin
      @(negedge clk);
      check("rstw_no_resp", {31'd0, ifu_resp_valid[1] | lsu_resp_valid[1]}, 32'd0);
      check("rstw_no_strobe", {31'd0, mem_ren[1] | mem_wen[1]}, 32'd0);
    end
    @(posedge clk); #1;
    ifu_req_valid[1] = 1; ifu_addr[1] = 32'h8000_0000;
    @(negedge clk);
    check("rstw_idle_after", 32'(ifu_req_ready[1]), 32'd1);
    @(posedge clk); #1;
    ifu_req_valid[1] = 0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
